// File: rtl/act_pool_ctrl.sv
// Pooling/activation sequencer: walks a W x H tile in raster order, applies ReLU
// and optional 2x2 stride-2 max pooling, and streams results to an output buffer.

module relu #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] dout_o
);
  assign dout_o = din_i[DATA_W-1] ? '0 : din_i;
endmodule

module act_pool_ctrl #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(MAX_W):0]     cfg_width,
  input  logic [ADDR_W-1:0]          cfg_height,
  input  logic                       cfg_relu_en,
  input  logic                       cfg_pool_en,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic signed [DATA_W-1:0]   rd_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic signed [DATA_W-1:0]   wr_data
);
  // state  | meaning
  // IDLE   | waiting for start; config sampled on start
  // RUN    | one read per cycle in raster order
  // DRAIN  | two cycles for the read/write pipeline to empty
  // DONE   | one-cycle done pulse
  localparam int CW  = $clog2(MAX_W) + 1;
  localparam int LBW = $clog2(MAX_W / 2);
  localparam int LBD = MAX_W / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q;
  logic [CW-1:0]             w_q;
  logic [ADDR_W-1:0]         h_q;
  logic                      relu_q, pool_q;
  logic                      busy_q, done_q, rd_en_q;
  logic [ADDR_W-1:0]         rd_addr_q;
  logic [ADDR_W-1:0]         ra_r_q;
  logic [CW-1:0]             ra_c_q;
  logic                      drain_q;
  logic                      vb_q, rb_odd_q;
  logic [LBW:0]              cb_q;
  logic signed [DATA_W-1:0]  hreg_q;
  logic                      wr_en_q;
  logic [ADDR_W-1:0]         wr_addr_q, wa_next_q;
  logic signed [DATA_W-1:0]  wr_data_q;
  logic signed [DATA_W-1:0]  lbuf_q [LBD];

  logic signed [DATA_W-1:0]  relu_out;
  logic signed [DATA_W-1:0]  v_d, m_d, lb_rd_d, pooled_d;
  logic                      last_col, last_row;

  relu #(.DATA_W(DATA_W)) u_relu (.din_i(rd_data), .dout_o(relu_out));

  always_comb begin
    v_d      = relu_q ? relu_out : rd_data;
    m_d      = (hreg_q > v_d) ? hreg_q : v_d;
    lb_rd_d  = lbuf_q[cb_q[LBW:1]];
    pooled_d = (lb_rd_d > m_d) ? lb_rd_d : m_d;
    last_col = (ra_c_q == w_q - CW'(1));
    last_row = (ra_r_q == h_q - ADDR_W'(1));
  end

  // Line buffer holds the horizontal max of each pair from the even row.
  always_ff @(posedge clk) begin
    if (vb_q && pool_q && cb_q[0] && !rb_odd_q)
      lbuf_q[cb_q[LBW:1]] <= m_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ra_r_q    <= '0;
      ra_c_q    <= '0;
      drain_q   <= 1'b0;
      vb_q      <= 1'b0;
      rb_odd_q  <= 1'b0;
      cb_q      <= '0;
      hreg_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wa_next_q <= '0;
      wr_data_q <= '0;
    end else begin
      vb_q     <= rd_en_q;
      rb_odd_q <= ra_r_q[0];
      cb_q     <= ra_c_q[LBW:0];
      wr_en_q  <= 1'b0;

      // Writes land in raster order in both modes, so a running counter is the address.
      if (vb_q) begin
        if (!pool_q) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= wa_next_q;
          wr_data_q <= v_d;
          wa_next_q <= wa_next_q + ADDR_W'(1);
        end else if (!cb_q[0]) begin
          hreg_q <= v_d;
        end else if (rb_odd_q) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= wa_next_q;
          wr_data_q <= pooled_d;
          wa_next_q <= wa_next_q + ADDR_W'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_q       <= cfg_width;
            h_q       <= cfg_height;
            relu_q    <= cfg_relu_en;
            pool_q    <= cfg_pool_en;
            ra_r_q    <= '0;
            ra_c_q    <= '0;
            rd_addr_q <= '0;
            wa_next_q <= '0;
            hreg_q    <= '0;
            if (cfg_width != '0 && cfg_height != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_col && last_row) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
            if (last_col) begin
              ra_c_q <= '0;
              ra_r_q <= ra_r_q + ADDR_W'(1);
            end else begin
              ra_c_q <= ra_c_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!drain_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= 1'b0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_act_pool_ctrl.sv
// Directed bench for act_pool_ctrl: buffer model, per-tile event log, immediate-assert checks.

module tb_act_pool_ctrl;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [5:0]        cfg_width = '0;
  logic [9:0]        cfg_height = '0;
  logic              cfg_relu_en = 1'b0;
  logic              cfg_pool_en = 1'b0;
  logic              busy, done, rd_en, wr_en;
  logic [9:0]        rd_addr, wr_addr;
  logic signed [7:0] rd_data = '0;
  logic signed [7:0] wr_data;

  logic signed [7:0] mem [1024];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0;
  bit log_on = 1'b0;
  int rd_n, rd_first, rd_last, wn, done_n, done_cyc, busy_n, busy_first, busy_last;
  int wa [64], wd [64], wt [64];

  act_pool_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_relu_en(cfg_relu_en), .cfg_pool_en(cfg_pool_en),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (log_on) begin
      if (rd_en) begin
        if (rd_n == 0) rd_first = cyc - t0;
        rd_last = cyc - t0;
        rd_n++;
      end
      if (wr_en && wn < 64) begin
        wa[wn] = int'(wr_addr);
        wd[wn] = int'($signed(wr_data));
        wt[wn] = cyc - t0;
        wn++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc - t0;
      end
      if (busy) begin
        if (busy_n == 0) busy_first = cyc - t0;
        busy_last = cyc - t0;
        busy_n++;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_n = 0; rd_first = -1; rd_last = -1; wn = 0;
    done_n = 0; done_cyc = -1; busy_n = 0; busy_first = -1; busy_last = -1;
  endtask

  task automatic run_tile(input int w, input int h, input bit relu_en, input bit pool_en,
                          input int extra_start, input int rst_at);
    clear_log();
    @(negedge clk);
    cfg_width = 6'(w); cfg_height = 10'(h);
    cfg_relu_en = relu_en; cfg_pool_en = pool_en;
    start = 1'b1;
    t0 = cyc;
    log_on = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k == extra_start);
      if (k == extra_start) begin
        cfg_width = 6'd8; cfg_pool_en = ~pool_en;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        clear_log();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (done_n > 0 && k >= done_cyc + 3) break;
    end
    log_on = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int exp_d [4];
    int exp_t [4];

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i - 8);

    // Reset state
    repeat (3) @(negedge clk);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_rd_en", int'(rd_en), 0);
    chk("init_wr_en", int'(wr_en), 0);
    chk("init_wr_data", int'(wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Bypass with ReLU, 4x4
    run_tile(4, 4, 1'b1, 1'b0, -1, -1);
    chk("byp_wr_count", wn, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("byp_addr%0d", i), wa[i], i);
      chk($sformatf("byp_data%0d", i), wd[i], (i < 8) ? 0 : i - 8);
      chk($sformatf("byp_wcyc%0d", i), wt[i], i + 3);
    end
    chk("byp_rd_count", rd_n, 16);
    chk("byp_rd_first", rd_first, 1);
    chk("byp_rd_last", rd_last, 16);
    chk("byp_done_cyc", done_cyc, 19);
    chk("byp_done_count", done_n, 1);
    chk("byp_busy_first", busy_first, 1);
    chk("byp_busy_last", busy_last, 18);
    chk("byp_busy_count", busy_n, 18);

    // Pool with ReLU
    run_tile(4, 4, 1'b1, 1'b1, -1, -1);
    exp_d = '{0, 0, 5, 7};
    exp_t = '{8, 10, 16, 18};
    chk("pr_wr_count", wn, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pr_addr%0d", i), wa[i], i);
      chk($sformatf("pr_data%0d", i), wd[i], exp_d[i]);
      chk($sformatf("pr_wcyc%0d", i), wt[i], exp_t[i]);
    end
    chk("pr_done_cyc", done_cyc, 19);

    // Pool without ReLU
    run_tile(4, 4, 1'b0, 1'b1, -1, -1);
    exp_d = '{-3, -1, 5, 7};
    chk("pn_wr_count", wn, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pn_addr%0d", i), wa[i], i);
      chk($sformatf("pn_data%0d", i), wd[i], exp_d[i]);
    end

    // Odd dimensions 5x3, buffer = addr
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    run_tile(5, 3, 1'b1, 1'b1, -1, -1);
    chk("odd_wr_count", wn, 2);
    chk("odd_addr0", wa[0], 0);
    chk("odd_addr1", wa[1], 1);
    chk("odd_data0", wd[0], 6);
    chk("odd_data1", wd[1], 8);
    chk("odd_rd_count", rd_n, 15);
    chk("odd_done_cyc", done_cyc, 18);

    // Zero width
    run_tile(0, 4, 1'b1, 1'b0, -1, -1);
    chk("zero_rd_count", rd_n, 0);
    chk("zero_wr_count", wn, 0);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_busy_count", busy_n, 0);

    // Reset mid-tile at cycle 6
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i - 8);
    run_tile(4, 4, 1'b1, 1'b0, -1, 6);
    chk("rstm_wr_after", wn, 0);
    chk("rstm_done_after", done_n, 0);
    chk("rstm_busy_after", busy_n, 0);

    // Fresh start after reset, ReLU off
    run_tile(4, 4, 1'b0, 1'b0, -1, -1);
    chk("fresh_wr_count", wn, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("fresh_data%0d", i), wd[i], i - 8);
    chk("fresh_done_cyc", done_cyc, 19);

    // Start pulse (with altered config) during busy is ignored
    run_tile(4, 4, 1'b1, 1'b1, 5, -1);
    exp_d = '{0, 0, 5, 7};
    chk("ign_wr_count", wn, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ign_data%0d", i), wd[i], exp_d[i]);
    chk("ign_done_count", done_n, 1);
    chk("ign_done_cyc", done_cyc, 19);
    chk("ign_rd_count", rd_n, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/act_pool_ctrl.md
# act_pool_ctrl

Sequencer for the pooling/activation stage. It walks a W×H feature-map tile stored in an on-chip activation buffer in raster order and applies the signed 8-bit ReLU (the existing `relu` block, instantiated once) to each element. It optionally applies 2×2 stride-2 max pooling, then writes results to an output buffer. It sits between the systolic-array result buffer and the next layer's input buffer, and is started by the layer controller through a start/busy/done handshake.

## Interface
- `DATA_W`, 8: element width, signed two's complement.
- `MAX_W`, 32: maximum tile width; sets the depth of the internal pooling line buffer (MAX_W/2 entries).
- `ADDR_W`, 10: buffer address width for both read and write ports.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a tile; sampled only in IDLE.
- `cfg_width` input $clog2(MAX_W)+1: tile width W, 0..MAX_W; latched on accepted start.
- `cfg_height` input ADDR_W: tile height H; latched on accepted start.
- `cfg_relu_en` input 1: 1 = apply ReLU, 0 = pass through; latched.
- `cfg_pool_en` input 1: 1 = 2×2 max pool, 0 = element-wise; latched.
- `busy` output 1: high while a tile is in progress.
- `done` output 1: one-cycle pulse at tile completion.
- `rd_en` output 1: activation buffer read strobe.
- `rd_addr` output ADDR_W: read address = r*W + c, modulo 2^ADDR_W.
- `rd_data` input DATA_W: read data, valid exactly 1 cycle after `rd_en`.
- `wr_en` output 1: output buffer write strobe.
- `wr_addr` output ADDR_W: write address.
- `wr_data` output DATA_W: write data.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 latches the config and clears the row and column counters r and c.
  - It goes to RUN if W≠0 and H≠0; otherwise it goes to DONE with no reads or writes.
- **RUN**
  - `rd_en`=1 every cycle with no gaps; c increments each cycle and wraps to 0 at W-1, at which point r increments.
  - After the read of (H-1, W-1) it goes to DRAIN.
- **DRAIN**: it waits 2 cycles for the pipeline to empty, then goes to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE, and the config inputs are ignored except on an accepted start.
- Processing path: `rd_data` goes through ReLU (if enabled) to give value v. ReLU maps negative to 0 and passes non-negative values unchanged. All comparisons are signed.
- **Pool off**: each v is written to `wr_addr` = r*W + c (same index as read).
- **Pool on**
  - Even c: v is held in a horizontal register h.
  - Odd c: m = max(h, v).
  - Even r: m is stored in the line buffer at index c/2.
  - Odd r: max(linebuf[c/2], m) is written to `wr_addr` = (r/2)*(W/2) + c/2.
  - Odd W or H: the trailing column or row is read but never written (floor semantics), giving floor(W/2)*floor(H/2) writes.
- Address arithmetic wraps modulo 2^ADDR_W. Keeping W*H ≤ 2^ADDR_W is the caller's responsibility.

## Timing
- Reset (async, `rst_n`=0): state goes to IDLE immediately. `busy`, `done`, `rd_en`, `wr_en`, `rd_addr`, `wr_addr`, `wr_data`, counters, h and pipeline valids all go to 0. Line buffer contents are don't-care.
- Reset mid-tile abandons the tile: no further `wr_en` and no `done`.
- Start accepted at cycle 0: first `rd_en` at cycle 1, last `rd_en` at cycle W*H.
- A read at cycle t returns data at t+1; the resulting write is registered and `wr_en` is high at t+2. The latency from a read to its write (or to the pooled write it completes) is 2 cycles.
- Last possible `wr_en` at cycle W*H+2; `done` at cycle W*H+3.
- `busy` is high from cycle 1 through cycle W*H+2 and low in the `done` cycle.
- Zero-dimension tile: `done` at cycle 1, `busy` never high.
- A new start is accepted in the cycle after `done` at the earliest.

## Test plan
- **Bypass with ReLU**
  - Stimulus: 4×4, relu=1, pool=0, buffer holds value = addr-8.
  - Required: 16 writes at addr 0..15, data max(addr-8, 0); `rd_en` high at cycles 1..16, `wr_en` at 3..18, `done` at 19.
- **Pool with ReLU**: same buffer, relu=1, pool=1 → exactly 4 writes, addr 0..3, data 0,0,5,7, at cycles 8,10,16,18.
- **Pool without ReLU**: same buffer, relu=0, pool=1 → data -3,-1,5,7.
- **Odd dimensions**: 5×3 pool, buffer = addr → 2 writes, addr 0,1, data 6,8; 15 reads; `done` at cycle 18.
- **Zero width**: W=0, H=4 → no `rd_en`, no `wr_en`, `done` at cycle 1.
- **Reset and start handling**
  - `rst_n` low at cycle 6 of a 4×4 run: all outputs 0 immediately, no `done`.
  - A fresh start then completes normally.
  - A `start` pulse during `busy` is ignored (write count unchanged).
